// File: rtl/alu_hilo_pkg.sv
// alu_hilo_pkg: shared types and helpers for the alu_hilo execute-stage ALU.
//   alu_func_t  - 5-bit operation code enumeration
//   alu_result  - combinational result of every non-sequential operation
// Optional feature macro: ALU_HILO_SIGNED_MUL_EN (adds the signed MULT code).
package alu_hilo_pkg;

  localparam int ALU_FUNC_W = 5;
  // The helper works on a fixed maximum width; callers zero-extend into it
  // and truncate the answer back to their own datapath width.
  localparam int ALU_MAX_W  = 64;
  localparam int ALU_SH_W   = 6;

  typedef enum logic [ALU_FUNC_W-1:0] {
    ALU_NONE = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_AND  = 5'd3,
    ALU_OR   = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_NOR  = 5'd6,
    ALU_SLT  = 5'd7,
    ALU_SLTU = 5'd8,
    ALU_SLL  = 5'd9,
    ALU_SRL  = 5'd10,
    ALU_SRA  = 5'd11,
    ALU_MULU = 5'd12,
    ALU_MFHI = 5'd13,
    ALU_MFLO = 5'd14,
    ALU_MTHI = 5'd15,
    ALU_MTLO = 5'd16
`ifdef ALU_HILO_SIGNED_MUL_EN
    , ALU_MULT = 5'd17
`endif
  } alu_func_t;

  // a, b, hi, lo are zero-extended w-bit values; the return value is only
  // meaningful in its low w bits (everything above is masked to zero).
  function automatic logic [ALU_MAX_W-1:0] alu_result(
    input alu_func_t             f,
    input logic [ALU_MAX_W-1:0]  a,
    input logic [ALU_MAX_W-1:0]  b,
    input logic [ALU_SH_W-1:0]   sh,
    input logic [ALU_MAX_W-1:0]  hi,
    input logic [ALU_MAX_W-1:0]  lo,
    input int unsigned           w
  );
    logic [ALU_MAX_W-1:0] mask;
    logic [ALU_MAX_W-1:0] a_s;
    logic [ALU_MAX_W-1:0] b_s;
    logic [ALU_MAX_W-1:0] r;
    mask = (w >= ALU_MAX_W) ? '1 : ((ALU_MAX_W'(1) << w) - ALU_MAX_W'(1));
    // Sign-extended copies give correct signed compare and arithmetic shift.
    a_s  = a[w-1] ? (a | ~mask) : a;
    b_s  = b[w-1] ? (b | ~mask) : b;
    r    = '0;
    case (f)
      ALU_ADD:  r = a + b;
      ALU_SUB:  r = a - b;
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = ($signed(a_s) < $signed(b_s)) ? ALU_MAX_W'(1) : '0;
      ALU_SLTU: r = (a < b) ? ALU_MAX_W'(1) : '0;
      ALU_SLL:  r = a << sh;
      ALU_SRL:  r = a >> sh;
      ALU_SRA:  r = $signed(a_s) >>> sh;
      ALU_MFHI: r = hi;
      ALU_MFLO: r = lo;
      default:  r = '0;   // NONE, MULU, MTHI, MTLO, MULT and unknown codes
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/alu_hilo_if.sv
// alu_hilo_if: operation bus between the pipeline control (master) and the
// ALU (slave).
//   func/data1/data2/shamt : operation request, master -> slave
//   result/zero/busy       : combinational result and multiply-busy, slave -> master
interface alu_hilo_if #(
  parameter int DATA_W = 32
);
  import alu_hilo_pkg::*;

  logic [ALU_FUNC_W-1:0]     func;
  logic [DATA_W-1:0]         data1;
  logic [DATA_W-1:0]         data2;
  logic [$clog2(DATA_W)-1:0] shamt;
  logic [DATA_W-1:0]         result;
  logic                      zero;
  logic                      busy;

  modport master (output func, data1, data2, shamt, input result, zero, busy);
  modport slave  (input func, data1, data2, shamt, output result, zero, busy);
endinterface

// File: rtl/alu_hilo_mul_pipe.sv
// alu_hilo_mul_pipe: DELAY-stage fully pipelined multiplier.
//   clock, reset_n : clock and asynchronous active-low reset
//   issue          : accept a new multiply on this edge
//   signed_op      : treat a/b as two's complement (else unsigned)
//   a, b           : operands
//   retire         : last stage holds a valid product (HI/LO written next edge)
//   product        : double-width product of the last stage
//   busy           : any stage valid
module alu_hilo_mul_pipe #(
  parameter int DATA_W = 32,
  parameter int DELAY  = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  issue,
  input  logic                  signed_op,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  retire,
  output logic [2*DATA_W-1:0]   product,
  output logic                  busy
);

  logic [DELAY-1:0]    valid_reg;
  logic [2*DATA_W-1:0] prod_reg [DELAY];
  logic [2*DATA_W-1:0] prod_u;
  logic [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_in;

  // The low 2*DATA_W bits of the product of sign-extended operands equal the
  // signed product, so one unsigned multiplier shape serves both flavours.
  assign prod_u  = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
  assign prod_s  = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_in = signed_op ? prod_s : prod_u;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= '0;
    end else begin
      valid_reg[0] <= issue;
      for (int i = 1; i < DELAY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
      end
    end
  end

  // Data stages need no reset: they are qualified by valid_reg.
  always_ff @(posedge clock) begin
    prod_reg[0] <= prod_in;
    for (int i = 1; i < DELAY; i++) begin
      prod_reg[i] <= prod_reg[i-1];
    end
  end

  assign retire  = valid_reg[DELAY-1];
  assign product = prod_reg[DELAY-1];
  assign busy    = |valid_reg;

endmodule

// File: rtl/alu_hilo.sv
// alu_hilo: MIPS execute-stage ALU with architectural HI/LO registers.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (clears HI, LO, multiply pipe)
//   bus     : alu_hilo_if.slave (func, data1, data2, shamt in;
//             result, zero, busy out)
// Optional feature macro: ALU_HILO_SIGNED_MUL_EN enables signed MULT (code 17).
// MFHI/MFLO have no interlock; the caller must stall while busy is high.
module alu_hilo
  import alu_hilo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DELAY  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  alu_hilo_if.slave   bus
);

  alu_func_t           f;
  logic [DATA_W-1:0]   hi_reg;
  logic [DATA_W-1:0]   lo_reg;
  logic                mul_issue;
  logic                mul_signed;
  logic                mul_retire;
  logic [2*DATA_W-1:0] mul_product;

  assign f = alu_func_t'(bus.func);

`ifdef ALU_HILO_SIGNED_MUL_EN
  assign mul_issue  = (f == ALU_MULU) || (f == ALU_MULT);
  assign mul_signed = (f == ALU_MULT);
`else
  assign mul_issue  = (f == ALU_MULU);
  assign mul_signed = 1'b0;
`endif

  alu_hilo_mul_pipe #(
    .DATA_W (DATA_W),
    .DELAY  (DELAY)
  ) u_mul_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .issue     (mul_issue),
    .signed_op (mul_signed),
    .a         (bus.data1),
    .b         (bus.data2),
    .retire    (mul_retire),
    .product   (mul_product),
    .busy      (bus.busy)
  );

  // MTHI/MTLO are assigned after the retiring product so they win for their
  // own register; the multiply still lands in the other one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else begin
      if (mul_retire) begin
        hi_reg <= mul_product[2*DATA_W-1:DATA_W];
        lo_reg <= mul_product[DATA_W-1:0];
      end
      if (f == ALU_MTHI) hi_reg <= bus.data1;
      if (f == ALU_MTLO) lo_reg <= bus.data1;
    end
  end

  assign bus.result = DATA_W'(alu_result(f,
                                         ALU_MAX_W'(bus.data1),
                                         ALU_MAX_W'(bus.data2),
                                         ALU_SH_W'(bus.shamt),
                                         ALU_MAX_W'(hi_reg),
                                         ALU_MAX_W'(lo_reg),
                                         DATA_W));
  assign bus.zero = (bus.result == '0);

endmodule

// File: tb/tb_alu_hilo.sv
// tb_alu_hilo: directed + randomized self-checking bench for alu_hilo
// (DATA_W=4, DELAY=2). The reference model keeps HI/LO as integers and the
// in-flight multiplies as a queue of (due cycle, hi, lo) entries.
module tb_alu_hilo;

  localparam int W     = 4;
  localparam int DELAY = 2;

  logic clock;
  logic reset_n;

  alu_hilo_if #(.DATA_W(W)) bus ();

  alu_hilo #(.DATA_W(W), .DELAY(DELAY)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int m_hi = 0, m_lo = 0, cycle = 0;
  int due_q[$];
  int phi_q[$];
  int plo_q[$];
  int cur_f = 0, cur_a = 0, cur_b = 0, cur_sh = 0;

  function automatic int sx(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  function automatic int ref_result(input int f, a, b, sh, hi, lo);
    case (f)
      1:  return (a + b) & 15;
      2:  return (a - b) & 15;
      3:  return a & b;
      4:  return a | b;
      5:  return a ^ b;
      6:  return (~(a | b)) & 15;
      7:  return (sx(a) < sx(b)) ? 1 : 0;
      8:  return (a < b) ? 1 : 0;
      9:  return (a << sh) & 15;
      10: return a >> sh;
      11: return (sx(a) >>> sh) & 15;
      13: return hi;
      14: return lo;
      default: return 0;
    endcase
  endfunction

  task automatic drive(input int f, input int a, input int b, input int sh);
    cur_f = f; cur_a = a; cur_b = b; cur_sh = sh;
    bus.func  = 5'(f);
    bus.data1 = 4'(a);
    bus.data2 = 4'(b);
    bus.shamt = 2'(sh);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0; m_lo = 0;
    due_q.delete(); phi_q.delete(); plo_q.delete();
  endtask

  task automatic model_edge();
    int p;
    bit is_mul;
    bit is_signed;
    cycle++;
    if (due_q.size() > 0 && due_q[0] == cycle) begin
      void'(due_q.pop_front());
      m_hi = phi_q.pop_front();
      m_lo = plo_q.pop_front();
    end
    if (cur_f == 15) m_hi = cur_a;
    if (cur_f == 16) m_lo = cur_a;
    is_mul = (cur_f == 12);
    is_signed = 1'b0;
`ifdef ALU_HILO_SIGNED_MUL_EN
    if (cur_f == 17) begin is_mul = 1'b1; is_signed = 1'b1; end
`endif
    if (is_mul) begin
      p = is_signed ? (sx(cur_a) * sx(cur_b)) & 255 : cur_a * cur_b;
      due_q.push_back(cycle + DELAY);
      phi_q.push_back((p >> 4) & 15);
      plo_q.push_back(p & 15);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic chk_model(input string tag);
    int e;
    e = ref_result(cur_f, cur_a, cur_b, cur_sh, m_hi, m_lo);
    chk({tag, "_result"}, {28'd0, bus.result}, 32'(e));
    chk({tag, "_zero"},   {31'd0, bus.zero},   (e == 0) ? 32'd1 : 32'd0);
    chk({tag, "_busy"},   {31'd0, bus.busy},   (due_q.size() != 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    model_reset();
    drive(0, 0, 0, 1);
    #12;
    chk("rst_result", {28'd0, bus.result}, 32'h0);
    chk("rst_zero",   {31'd0, bus.zero},   32'h1);
    chk("rst_busy",   {31'd0, bus.busy},   32'h0);
    drive(13, 0, 0, 1); #1;
    chk("rst_mfhi",   {28'd0, bus.result}, 32'h0);
    drive(14, 0, 0, 1); #1;
    chk("rst_mflo",   {28'd0, bus.result}, 32'h0);
    reset_n = 1'b1;
    drive(0, 0, 0, 1);
    tick();

    // Basic arithmetic/logic
    drive(1, 7, 3, 1); #1;
    chk("add_result", {28'd0, bus.result}, 32'ha);
    chk("add_zero",   {31'd0, bus.zero},   32'h0);
    drive(6, 5, 3, 1); #1;
    chk("nor_result", {28'd0, bus.result}, 32'h8);
    tick();

    // MULU a*a = 0x64, busy for two cycles
    drive(12, 10, 10, 1); #1;
    chk("mulu_result", {28'd0, bus.result}, 32'h0);
    tick();
    drive(0, 0, 0, 1); #1;
    chk("mulu_busy1", {31'd0, bus.busy}, 32'h1);
    tick();
    chk("mulu_busy2", {31'd0, bus.busy}, 32'h1);
    tick();
    chk("mulu_busy_done", {31'd0, bus.busy}, 32'h0);
    drive(13, 0, 0, 1); #1;
    chk("mulu_mfhi", {28'd0, bus.result}, 32'h6);
    drive(14, 0, 0, 1); #1;
    chk("mulu_mflo", {28'd0, bus.result}, 32'h4);
    tick();

    // MTHI then read back; LO untouched
    drive(15, 10, 0, 1); #1;
    chk("mthi_result", {28'd0, bus.result}, 32'h0);
    tick();
    drive(13, 0, 0, 1); #1;
    chk("mthi_mfhi", {28'd0, bus.result}, 32'ha);
    drive(14, 0, 0, 1); #1;
    chk("mthi_mflo", {28'd0, bus.result}, 32'h4);
    tick();

    // Shifts and XOR-to-zero
    drive(9, 5, 0, 1);   #1; chk("sll",  {28'd0, bus.result}, 32'ha);
    drive(11, 10, 0, 1); #1; chk("sra",  {28'd0, bus.result}, 32'hd);
    drive(10, 10, 0, 2); #1; chk("srl",  {28'd0, bus.result}, 32'h2);
    drive(5, 15, 15, 1); #1; chk("xor_result", {28'd0, bus.result}, 32'h0);
    chk("xor_zero", {31'd0, bus.zero}, 32'h1);
    tick();

    // Reset one edge after MULU issue cancels the product
    drive(12, 3, 5, 1); #1;
    tick();
    drive(0, 0, 0, 1); #1;
    chk("rstmul_busy_before", {31'd0, bus.busy}, 32'h1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rstmul_busy_in_rst", {31'd0, bus.busy}, 32'h0);
    drive(13, 0, 0, 1); #1;
    chk("rstmul_hi_in_rst", {28'd0, bus.result}, 32'h0);
    reset_n = 1'b1;
    drive(0, 0, 0, 1);
    tick();
    tick();
    tick();
    chk("rstmul_busy_after", {31'd0, bus.busy}, 32'h0);
    drive(13, 0, 0, 1); #1;
    chk("rstmul_mfhi", {28'd0, bus.result}, 32'h0);
    drive(14, 0, 0, 1); #1;
    chk("rstmul_mflo", {28'd0, bus.result}, 32'h0);
    tick();

    // MULU 7*6 = 0x2a retires on the same edge as an MTHI of 5
    drive(12, 7, 6, 1); #1;
    tick();
    drive(0, 0, 0, 1); #1;
    tick();
    drive(15, 5, 0, 1); #1;
    tick();
    drive(13, 0, 0, 1); #1;
    chk("coll_mfhi", {28'd0, bus.result}, 32'h5);
    drive(14, 0, 0, 1); #1;
    chk("coll_mflo", {28'd0, bus.result}, 32'ha);
    chk("coll_busy", {31'd0, bus.busy},   32'h0);
    tick();

    // Randomized operations against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        reset_n = 1'b1;
      end
      drive(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      #1;
      chk_model("rand");
      tick();
    end

    // Drain and read the final HI/LO
    drive(0, 0, 0, 1);
    for (int i = 0; i < DELAY + 1; i++) tick();
    drive(13, 0, 0, 1); #1;
    chk_model("final_mfhi");
    drive(14, 0, 0, 1); #1;
    chk_model("final_mflo");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
